// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
//   XLEN_DEFAULT  : default data width
//   NREGS_DEFAULT : default register count
//   NRD_DEFAULT   : default number of read ports
//   addr_width()  : register-address width for a given register count
package regfile_pkg;

  localparam int unsigned XLEN_DEFAULT  = 32;
  localparam int unsigned NREGS_DEFAULT = 32;
  localparam int unsigned NRD_DEFAULT   = 2;

  // A register file always has at least two entries, so the width is at least 1.
  function automatic int unsigned addr_width(input int unsigned nregs);
    return (nregs < 2) ? 1 : $clog2(nregs);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-bit scoreboard for long-latency destination registers.
//   clk, rst          : clock, synchronous active-high reset
//   i_clr_en/addr     : accepted long-latency writeback, clears its pending bit
//   i_alloc_valid/addr: allocation request, sets the pending bit when accepted
//   o_alloc_ready_c   : allocation accepted this cycle (combinational)
//   o_pending         : registered scoreboard state
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS    = NREGS_DEFAULT,
  parameter bit          ZERO_REG = 1'b1,
  localparam int unsigned AW      = addr_width(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr_en,
  input  logic [AW-1:0]    i_clr_addr,
  input  logic             i_alloc_valid,
  input  logic [AW-1:0]    i_alloc_addr,
  output logic             o_alloc_ready_c,
  output logic [NREGS-1:0] o_pending
);

  logic [NREGS-1:0] r_pending;
  logic [NREGS-1:0] w_pending_nxt;
  logic             w_alloc_fire;
  logic             w_alloc_set;

  // A pending register may be re-allocated only when its result lands this cycle.
  always_comb begin
    o_alloc_ready_c = !r_pending[i_alloc_addr] ||
                      (i_clr_en && (i_clr_addr == i_alloc_addr));
    w_alloc_fire    = i_alloc_valid && o_alloc_ready_c;
    w_alloc_set     = w_alloc_fire && !(ZERO_REG && (i_alloc_addr == '0));
  end

  // Clear first, then set, so a same-cycle clear+set of one register leaves it pending.
  always_comb begin
    w_pending_nxt = r_pending;
    if (i_clr_en) begin
      w_pending_nxt[i_clr_addr] = 1'b0;
    end
    if (w_alloc_set) begin
      w_pending_nxt[i_alloc_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  assign o_pending = r_pending;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write scoreboard and optional bypass.
//   clk, rst                 : clock, synchronous active-high reset
//   rs_addr/rs_data/rs_busy  : NRD combinational read ports (packed, port i at [i*W +: W])
//   wp0_en/addr/data         : single-cycle pipeline writeback, always wins conflicts
//   wp1_valid/ready/addr/data: long-latency writeback handshake, clears pending
//   alloc_valid/ready/addr   : destination allocation, sets pending
//   pending                  : scoreboard state
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEFAULT,
  parameter int unsigned NREGS    = NREGS_DEFAULT,
  parameter int unsigned NRD      = NRD_DEFAULT,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned AW      = addr_width(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_busy,
  input  logic                wp0_en,
  input  logic [AW-1:0]       wp0_addr,
  input  logic [XLEN-1:0]     wp0_data,
  input  logic                wp1_valid,
  output logic                wp1_ready,
  input  logic [AW-1:0]       wp1_addr,
  input  logic [XLEN-1:0]     wp1_data,
  input  logic                alloc_valid,
  output logic                alloc_ready,
  input  logic [AW-1:0]       alloc_addr,
  output logic [NREGS-1:0]    pending
);

  logic [XLEN-1:0]  r_mem [NREGS];
  logic             w_wp1_fire;
  logic             w_wp0_we;
  logic             w_wp1_we;
  logic [NREGS-1:0] w_pending;

  // wp1 stalls only on an address clash with wp0, so the two writes never collide.
  always_comb begin
    wp1_ready  = !(wp0_en && (wp0_addr == wp1_addr));
    w_wp1_fire = wp1_valid && wp1_ready;
    w_wp0_we   = wp0_en && !(ZERO_REG && (wp0_addr == '0));
    w_wp1_we   = w_wp1_fire && !(ZERO_REG && (wp1_addr == '0));
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wp0_we) begin
        r_mem[wp0_addr] <= wp0_data;
      end
      if (w_wp1_we) begin
        r_mem[wp1_addr] <= wp1_data;
      end
    end
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk             (clk),
    .rst             (rst),
    .i_clr_en        (w_wp1_fire),
    .i_clr_addr      (wp1_addr),
    .i_alloc_valid   (alloc_valid),
    .i_alloc_addr    (alloc_addr),
    .o_alloc_ready_c (alloc_ready),
    .o_pending       (w_pending)
  );

  assign pending = w_pending;

  // Per-port read mux: hardwired zero, then same-cycle bypass, then storage.
  for (genvar g = 0; g < int'(NRD); g++) begin : g_rd
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_data;
    logic            w_busy;

    always_comb begin
      w_addr = rs_addr[g*AW +: AW];
      w_data = r_mem[w_addr];
      if (ZERO_REG && (w_addr == '0)) begin
        w_data = '0;
      end else if (BYPASS && w_wp0_we && (wp0_addr == w_addr)) begin
        w_data = wp0_data;
      end else if (BYPASS && w_wp1_we && (wp1_addr == w_addr)) begin
        w_data = wp1_data;
      end
      // The landing wp1 result resolves the hazard in the same cycle.
      w_busy = w_pending[w_addr] && !(BYPASS && w_wp1_fire && (wp1_addr == w_addr));
    end

    assign rs_data[g*XLEN +: XLEN] = w_data;
    assign rs_busy[g]              = w_busy;
  end

endmodule
